// File: rtl/muldiv_wb.sv
// Iterative RV32M multiply/divide unit driving the register file's second write port.
// Radix-2: 32 shift-add or restoring-divide steps, then a single write-back cycle.
module muldiv_wb #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic [4:0]      rd,
   input  logic            kill,
   output logic            busy,
   output logic            we,
   output logic [4:0]      waddr,
   output logic [XLEN-1:0] wdata,
   output logic            done
);

   typedef enum logic [1:0] {IDLE, CALC, WB} state_t;

   state_t      state, state_n;
   logic [4:0]  cnt;
   logic [2:0]  fq;
   logic [4:0]  rdq;
   logic        negp, negr;
   logic [63:0] opa, acc;
   logic [31:0] opb;

   logic        sg1, sg2, neg1, neg2;
   logic [31:0] mag1, mag2;
   logic        dz, ovf, accept;
   logic [32:0] sh, trial;
   logic [63:0] acc_n, opa_n, pm;
   logic [31:0] opb_n, qf, rf, res;

   always_comb begin
      sg1 = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
      sg2 = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01);
      neg1 = sg1 & rs1[31];
      neg2 = sg2 & rs2[31];
      mag1 = neg1 ? ~rs1 + 32'd1 : rs1;
      mag2 = neg2 ? ~rs2 + 32'd1 : rs2;
      dz = funct3[2] && (rs2 == 32'd0);
      ovf = funct3[2] && !funct3[0] && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
      accept = (state == IDLE) && start && !kill;
   end

   // One iteration: divide reuses acc as partial remainder and opa as quotient shifter.
   always_comb begin
      sh = {acc[31:0], opa[31]};
      trial = sh - {1'b0, opb};
      if (fq[2]) begin
         acc_n = {31'd0, trial[32] ? sh : trial};
         opa_n = {32'd0, opa[30:0], ~trial[32]};
         opb_n = opb;
      end else begin
         acc_n = opb[0] ? acc + opa : acc;
         opa_n = opa << 1;
         opb_n = opb >> 1;
      end
      pm = negp ? ~acc_n + 64'd1 : acc_n;
      qf = negp ? ~opa_n[31:0] + 32'd1 : opa_n[31:0];
      rf = negr ? ~acc_n[31:0] + 32'd1 : acc_n[31:0];
      if (fq[2]) res = fq[1] ? rf : qf;
      else res = (fq[1:0] == 2'b00) ? pm[31:0] : pm[63:32];
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: if (start) state_n = (dz || ovf) ? WB : CALC;
         CALC: if (cnt == 5'd31) state_n = WB;
         WB:   state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (kill) state_n = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 5'd0;
         fq    <= 3'd0;
         rdq   <= 5'd0;
         negp  <= 1'b0;
         negr  <= 1'b0;
         opa   <= 64'd0;
         acc   <= 64'd0;
         opb   <= 32'd0;
         waddr <= 5'd0;
         wdata <= 32'd0;
      end else begin
         state <= state_n;
         if (accept) begin
            cnt  <= 5'd0;
            fq   <= funct3;
            rdq  <= rd;
            negp <= neg1 ^ neg2;
            negr <= neg1;
            opa  <= {32'd0, mag1};
            opb  <= mag2;
            acc  <= 64'd0;
            if (dz) begin
               waddr <= rd;
               wdata <= funct3[1] ? rs1 : 32'hFFFF_FFFF;
            end else if (ovf) begin
               waddr <= rd;
               wdata <= funct3[1] ? 32'd0 : 32'h8000_0000;
            end
         end else if (state == CALC && !kill) begin
            cnt <= cnt + 5'd1;
            acc <= acc_n;
            opa <= opa_n;
            opb <= opb_n;
            if (cnt == 5'd31) begin
               waddr <= rdq;
               wdata <= res;
            end
         end
      end
   end

   always_comb begin
      busy = (state != IDLE);
      done = (state == WB) && !kill && !rst;
      we   = done && (waddr != 5'd0);
   end

endmodule

// File: tb/tb_muldiv_wb.sv
// Directed bench for muldiv_wb: scoreboard of expected write-backs, latency,
// x0, ignored start, kill and mid-op reset.
module tb_muldiv_wb;

   logic        clk = 1'b0;
   logic        rst, start, kill;
   logic [2:0]  funct3;
   logic [31:0] rs1, rs2;
   logic [4:0]  rd;
   logic        busy, we, done;
   logic [4:0]  waddr;
   logic [31:0] wdata;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int we_cnt = 0;

   typedef struct {
      logic        we;
      logic [4:0]  a;
      logic [31:0] d;
      int          lat;
   } exp_t;
   exp_t sb[$];

   muldiv_wb #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .start(start), .funct3(funct3),
      .rs1(rs1), .rs2(rs2), .rd(rd), .kill(kill),
      .busy(busy), .we(we), .waddr(waddr), .wdata(wdata), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
      if (we) we_cnt <= we_cnt + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
      logic signed [63:0] sa, sb2, ua, ub, p;
      sa  = {{32{a[31]}}, a};
      sb2 = {{32{b[31]}}, b};
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      ref_op = 32'd0;
      case (f)
         3'd0: begin p = ua * ub; ref_op = p[31:0]; end
         3'd1: begin p = sa * sb2; ref_op = p[63:32]; end
         3'd2: begin p = sa * ub; ref_op = p[63:32]; end
         3'd3: begin p = ua * ub; ref_op = p[63:32]; end
         3'd4: ref_op = (b == 0) ? 32'hFFFF_FFFF :
                        (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 :
                        32'($signed(a) / $signed(b));
         3'd5: ref_op = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: ref_op = (b == 0) ? a :
                        (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 :
                        32'($signed(a) % $signed(b));
         default: ref_op = (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int lat_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (f[2] && b == 0) return 1;
      if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   // Issues one op in the current cycle; expected data is given by the caller.
   // glitch>0 pulses a second start (with altered operands) at cycle E+glitch.
   task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r,
                        input logic [31:0] expd, input int glitch);
      exp_t e;
      exp_t got;
      int n;
      int d0;
      e.we = (r != 0);
      e.a = r;
      e.d = expd;
      e.lat = lat_of(f, a, b);
      sb.push_back(e);
      d0 = done_cnt;
      funct3 = f; rs1 = a; rs2 = b; rd = r; start = 1'b1;
      step();
      start = 1'b0;
      n = 1;
      chk({tag, "_busy_rise"}, busy, 1);
      while (!done && n < 40) begin
         if (n == glitch) begin
            start = 1'b1; rs1 = 32'h1234_5678; rs2 = 32'h3; rd = 5'd31; funct3 = 3'd5;
         end
         step();
         start = 1'b0;
         rs1 = 32'hDEAD_BEEF; rs2 = 32'h0; rd = 5'd9;
         n++;
      end
      got = sb.pop_front();
      chk({tag, "_lat"}, n, got.lat);
      chk({tag, "_busy_wb"}, busy, 1);
      chk({tag, "_wdata"}, wdata, got.d);
      chk({tag, "_we"}, we, got.we);
      chk({tag, "_waddr"}, waddr, got.a);
      step();
      chk({tag, "_done_1cyc"}, done, 0);
      chk({tag, "_busy_fall"}, busy, 0);
      chk({tag, "_ndone"}, done_cnt - d0, 1);
   endtask

   initial begin
      int d0, w0, k;
      logic [2:0]  rf;
      logic [31:0] ra, rb;
      rst = 1'b1; start = 1'b0; kill = 1'b0;
      funct3 = 3'd0; rs1 = 32'd0; rs2 = 32'd0; rd = 5'd0;
      step(); step();
      rst = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_we", we, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_done", done, 0);

      do_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 0);
      do_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 0);
      do_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 0);
      do_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFD, 0);
      do_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFF, 0);
      do_op("divu", 3'd5, 32'd100, 32'd7, 5'd10, 32'd14, 0);
      do_op("remu", 3'd7, 32'd100, 32'd7, 5'd11, 32'd2, 0);
      do_op("divu0", 3'd5, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF, 0);
      do_op("rem0", 3'd6, 32'd5, 32'd0, 5'd13, 32'd5, 0);
      do_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 0);
      do_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, 0);
      do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16, 32'hFFFF_FFFF, 0);
      do_op("mul_x0", 3'd0, 32'd3, 32'd4, 5'd0, 32'd12, 0);
      do_op("ign_start", 3'd0, 32'd6, 32'd9, 5'd17, 32'd54, 5);

      // Kill mid-CALC, then a fresh op issued in the cycle busy drops.
      d0 = done_cnt; w0 = we_cnt;
      funct3 = 3'd0; rs1 = 32'd5; rs2 = 32'd5; rd = 5'd18; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i < 10; i++) step();
      kill = 1'b1;
      step();
      kill = 1'b0;
      chk("kill_busy", busy, 0);
      chk("kill_nodone", done_cnt - d0, 0);
      do_op("after_kill", 3'd5, 32'd100, 32'd7, 5'd19, 32'd14, 0);
      chk("kill_we_total", we_cnt - w0, 1);

      // Kill landing in the write-back cycle.
      d0 = done_cnt; w0 = we_cnt;
      funct3 = 3'd0; rs1 = 32'd2; rs2 = 32'd3; rd = 5'd20; start = 1'b1;
      step();
      start = 1'b0;
      k = 1;
      while (!busy || (k < 33 && k < 40)) begin step(); k++; end
      kill = 1'b1;
      #1;
      chk("killwb_we", we, 0);
      chk("killwb_done", done, 0);
      step();
      kill = 1'b0;
      chk("killwb_busy", busy, 0);
      for (int i = 0; i < 3; i++) step();
      chk("killwb_nowe", we_cnt - w0, 0);
      chk("killwb_nodone", done_cnt - d0, 0);

      // Reset in the middle of an op.
      d0 = done_cnt;
      funct3 = 3'd4; rs1 = 32'd50; rs2 = 32'd3; rd = 5'd21; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i < 20; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rstmid_busy", busy, 0);
      chk("rstmid_we", we, 0);
      chk("rstmid_waddr", waddr, 0);
      chk("rstmid_wdata", wdata, 0);
      chk("rstmid_done", done, 0);
      for (int i = 0; i < 40; i++) step();
      chk("rstmid_nodone", done_cnt - d0, 0);
      do_op("after_rst", 3'd4, 32'd100, 32'd7, 5'd22, 32'd14, 0);

      for (int i = 0; i < 10; i++) begin
         rf = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = (i == 3) ? 32'd0 : $urandom;
         if (i == 5) rb = 32'd1;
         do_op("rand", rf, ra, rb, 5'(i + 1), ref_op(rf, ra, rb), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_wb.md
# muldiv_wb

Iterative RV32M multiply/divide unit; the producer on the register file's second write port (`we2`/`waddr2`/`wdata2`).

- Accepts one operation per start handshake.
- Computes the result over 32 radix-2 iterations.
- Delivers the result as a single-cycle register write.
- The register file gives its first (pipeline) port priority on a same-address collision. This block therefore needs no arbitration, but it must honour x0 and kill.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request pulse; sampled only when `busy`=0.
- `funct3`  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1`, `rs2`  in  32  operands (rs1 = multiplicand/dividend).
- `rd`  in  5  destination register.
- `kill`  in  1  abort in-flight op (pipeline flush).
- `busy`  out  1  op accepted and not yet written back.
- `we`  out  1  write enable to the register file port 2.
- `waddr`  out  5  write address.
- `wdata`  out  32  write data.
- `done`  out  1  completion pulse; also fires for rd=0.

## Operation
- States: IDLE, CALC, WB.
- **IDLE**:
  - `start`=1 latches `funct3`, `rd`, and the operand magnitudes, then goes to CALC.
  - Sign handling: DIV/REM/MULH take both operands as signed; MULHSU takes rs1 signed, rs2 unsigned; the rest are unsigned.
  - Special cases go directly to WB instead of CALC:
    - Divide by zero: quotient 0xFFFFFFFF, remainder = rs1.
    - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM): quotient 0x80000000, remainder 0.
- **CALC**:
  - 5-bit counter runs 0..31; one iteration per cycle.
  - Multiply: shift-add into a 64-bit product.
  - Divide: restoring divide with a 33-bit partial remainder.
  - When count=31, go to WB and register the result into `wdata`:
    - Sign fix: product negated if the operand signs differ (signed-operand case).
    - Quotient negated if signs differ; remainder takes the dividend's sign.
    - MUL selects product[31:0]; MULH/MULHSU/MULHU select product[63:32].
- **WB**:
  - One cycle.
  - `we`=1 if rd≠0, else 0.
  - `waddr`=rd; `done`=1.
  - Next state IDLE.
- `busy`=1 in CALC and WB.
- `start` while `busy`=1 is ignored; there is no queueing.
- `kill`=1 in any state:
  - Next state IDLE.
  - `we`/`done` forced 0 in the same cycle, including WB.
  - Latched op discarded.
- `kill` and `start` together in IDLE: kill wins; nothing is accepted.
- `rst` has priority over everything; a reset mid-operation abandons the op.
- The unit does not guarantee the write lands. If port 1 writes the same address in the WB cycle, the register file keeps the port-1 data. Hazard logic upstream owns that case.

## Timing
- Reset values: `busy`=0, `we`=0, `waddr`=0, `wdata`=0, `done`=0; state IDLE; counter 0.
- Normal latency:
  - `start` sampled at edge E.
  - CALC occupies cycles E+1..E+32.
  - `we`/`done` high during cycle E+33, for exactly one cycle.
- Special-case latency: `we`/`done` high during cycle E+1.
- `busy` rises the cycle after accepting `start` and falls the cycle after WB.
- Back-to-back ops: the earliest next `start` is accepted in the first IDLE cycle after WB. Minimum issue interval is 34 cycles (2 for special cases).
- `waddr`/`wdata` are registered and stable for the whole WB cycle. Outside WB they hold their last values, and `we`=0.
- Operands are captured at acceptance; changes to `rs1`/`rs2`/`rd` afterwards have no effect.

## Test plan
- Multiply low/high:
  - MUL 7 × 0xFFFFFFFD (−3) → `wdata`=0xFFFFFFEB, `we`=1 at E+33, `busy` high E+1..E+33.
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- Signed divide/remainder:
  - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD.
  - REM same operands → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
- Special cases:
  - DIVU 5/0 → 0xFFFFFFFF at E+1.
  - REM 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF → 0.
- x0 and ignored start:
  - MUL with rd=0 → `done`=1 with `we`=0 at E+33.
  - `start` pulsed at E+5 while busy → ignored; exactly one `done` is observed.
- Kill:
  - Assert `kill` at E+10 → `busy`=0 at E+11, no `we` ever.
  - Kill asserted in the WB cycle → `we`=0 that cycle.
  - New `start` at E+11 completes normally.
- Reset mid-op:
  - `rst` at E+20 → all outputs 0 the next cycle, no write-back.
  - A following DIV 100/7 → 14 at 33-cycle latency.
